// File: rtl/asip_pkg.sv
// Shared ASIP constants and enums for the control-flow redirect path.
package asip_pkg;
  localparam int PC_W    = 8;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    BR_JMP = 3'd0,
    BR_BEQ = 3'd1,
    BR_BNE = 3'd2,
    BR_BLT = 3'd3,
    BR_BGE = 3'd4
  } br_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDIRECT,
    ST_FLUSH
  } redir_state_t;
endpackage

// File: rtl/pc_redirect_unit_branch_cond.sv
// Branch condition evaluator: {brType, N, Z} -> taken. Reserved types never take.
module branch_cond
  import asip_pkg::*;
(
  input  logic [2:0] brType_i,
  input  logic       flagN_i,
  input  logic       flagZ_i,
  output logic       taken_o
);

  // Decode branch type against the registered flags
  always_comb begin
    taken_o = 1'b0;
    case (brType_i)
      BR_JMP:  taken_o = 1'b1;
      BR_BEQ:  taken_o = flagZ_i;
      BR_BNE:  taken_o = ~flagZ_i;
      BR_BLT:  taken_o = flagN_i;
      BR_BGE:  taken_o = ~flagN_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: resolves execute-stage branches, issues a one-cycle PC
// write to fetch and holds IF/ID + ID/EX flush for FLUSH_CYCLES cycles.
// Optional build macro PC_REDIRECT_STATS_EN adds taken/not-taken counters.
// PC_STEP is assumed to be a power of two (alignment is a low-bit mask).
module pc_redirect_unit #(
  parameter int PC_W         = asip_pkg::PC_W,
  parameter int PC_STEP      = asip_pkg::PC_STEP,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flagWrEn,
  input  logic [1:0]      flagsIn,
  input  logic            brValid,
  input  logic [2:0]      brType,
  input  logic [PC_W-1:0] brPc,
  input  logic [PC_W-1:0] brOffset,
  output logic            pcWrEn,
  output logic [PC_W-1:0] newPc,
  output logic            flushIF,
  output logic            flushID,
  output logic            busy,
`ifdef PC_REDIRECT_STATS_EN
  output logic [15:0]     takenCnt,
  output logic [15:0]     notTakenCnt,
`endif
  output logic            alignErr
);
  import asip_pkg::*;

  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(PC_STEP - 1);
  localparam logic [2:0]      CNT_LOAD   = 3'(FLUSH_CYCLES - 1);

  logic [1:0]      flags_q;  // {N, Z}
  redir_state_t    state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pcWrEn_q, pcWrEn_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic            alignErr_q, alignErr_d;
  logic [PC_W-1:0] newPc_q, newPc_d;
  logic            taken;
  logic [PC_W-1:0] target;
  logic            misal;

  branch_cond u_cond (
    .brType_i (brType),
    .flagN_i  (flags_q[1]),
    .flagZ_i  (flags_q[0]),
    .taken_o  (taken)
  );

  // Signed offset times step wraps naturally in PC_W-bit arithmetic
  assign target = brPc + (brOffset * PC_W'(PC_STEP));
  assign misal  = |(target & ALIGN_MASK);

  // Flag register; a same-cycle branch sees the old value
  always_ff @(posedge clk) begin
    if (reset)         flags_q <= 2'b00;
    else if (flagWrEn) flags_q <= flagsIn;
  end

  // FSM state and flush counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; brValid is only looked at in IDLE (wrong path otherwise)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:     if (brValid && taken) state_d = ST_REDIRECT;
      ST_REDIRECT: begin
        cnt_d   = CNT_LOAD;
        state_d = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output next-values, derived from the upcoming state so outputs are registered
  always_comb begin
    pcWrEn_d   = (state_d == ST_REDIRECT);
    flush_d    = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    newPc_d    = newPc_q;
    alignErr_d = alignErr_q;
    if (state_q == ST_IDLE && state_d == ST_REDIRECT) begin
      newPc_d    = target & ~ALIGN_MASK;
      alignErr_d = alignErr_q | misal;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pcWrEn_q   <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      alignErr_q <= 1'b0;
      newPc_q    <= '0;
    end else begin
      pcWrEn_q   <= pcWrEn_d;
      flush_q    <= flush_d;
      busy_q     <= busy_d;
      alignErr_q <= alignErr_d;
      newPc_q    <= newPc_d;
    end
  end

  assign pcWrEn   = pcWrEn_q;
  assign newPc    = newPc_q;
  assign flushIF  = flush_q;
  assign flushID  = flush_q;
  assign busy     = busy_q;
  assign alignErr = alignErr_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] takenCnt_q, notTakenCnt_q;

  // Saturating counts of branches evaluated in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      takenCnt_q    <= 16'd0;
      notTakenCnt_q <= 16'd0;
    end else if (state_q == ST_IDLE && brValid) begin
      if (taken && takenCnt_q != 16'hFFFF)        takenCnt_q    <= takenCnt_q + 16'd1;
      if (!taken && notTakenCnt_q != 16'hFFFF)    notTakenCnt_q <= notTakenCnt_q + 16'd1;
    end
  end

  assign takenCnt    = takenCnt_q;
  assign notTakenCnt = notTakenCnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit (default parameters, FLUSH_CYCLES=2).
// Expected redirect targets go into a scoreboard queue when a taken branch is
// driven; a negedge monitor pops and compares whenever pcWrEn fires.
module tb_pc_redirect_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flagWrEn = 1'b0;
  logic [1:0] flagsIn = 2'b00;
  logic       brValid = 1'b0;
  logic [2:0] brType = 3'd0;
  logic [7:0] brPc = 8'h00;
  logic [7:0] brOffset = 8'h00;
  logic       pcWrEn, flushIF, flushID, busy, alignErr;
  logic [7:0] newPc;
`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] takenCnt, notTakenCnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk      (clk),
    .reset    (reset),
    .flagWrEn (flagWrEn),
    .flagsIn  (flagsIn),
    .brValid  (brValid),
    .brType   (brType),
    .brPc     (brPc),
    .brOffset (brOffset),
    .pcWrEn   (pcWrEn),
    .newPc    (newPc),
    .flushIF  (flushIF),
    .flushID  (flushID),
    .busy     (busy),
`ifdef PC_REDIRECT_STATS_EN
    .takenCnt    (takenCnt),
    .notTakenCnt (notTakenCnt),
`endif
    .alignErr (alignErr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic pw, input logic fl, input logic bz);
    chk({tag, ".pcWrEn"},  {31'd0, pcWrEn},  {31'd0, pw});
    chk({tag, ".flushIF"}, {31'd0, flushIF}, {31'd0, fl});
    chk({tag, ".flushID"}, {31'd0, flushID}, {31'd0, fl});
    chk({tag, ".busy"},    {31'd0, busy},    {31'd0, bz});
  endtask

  // Drive one branch for a single cycle; a taken one queues its expected target
  task automatic br(input logic [2:0] t, input logic [7:0] pc, input logic [7:0] off,
                    input bit push, input logic [7:0] exp);
    brType = t; brPc = pc; brOffset = off; brValid = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    brValid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (pcWrEn) begin
      if (exp_q.size() == 0) chk("redirect_unexpected", 32'd1, 32'd0);
      else                   chk("newPc", {24'd0, newPc}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    // Reset and idle
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle", 1'b0, 1'b0, 1'b0);
    end
    chk("idle.alignErr", {31'd0, alignErr}, 32'd0);
    chk("idle.newPc", {24'd0, newPc}, 32'd0);

    // Z=1, BEQ taken: 0x10 + 3*4 = 0x1C
    flagWrEn = 1'b1; flagsIn = 2'b01; tick(); flagWrEn = 1'b0;
    br(3'd1, 8'h10, 8'd3, 1'b1, 8'h1C);
    chk_out("beq_n1", 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("beq_n2", 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("beq_n3", 1'b0, 1'b0, 1'b0);
    chk("beq.newPc_hold", {24'd0, newPc}, 32'h1C);

    // Z=1, BNE not taken
    br(3'd2, 8'h10, 8'd3, 1'b0, 8'h00);
    chk_out("bne_n1", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("bne_n2", 1'b0, 1'b0, 1'b0);

    // JMP wrap forward, then JMP accepted on the first post-flush cycle (backward wrap)
    br(3'd0, 8'hFC, 8'd1, 1'b1, 8'h00);
    chk_out("jmp_wrap_n1", 1'b1, 1'b1, 1'b1);
    tick(); tick();
    br(3'd0, 8'h04, 8'hFE, 1'b1, 8'hFC);
    chk_out("jmp_back_n1", 1'b1, 1'b1, 1'b1);
    tick(); tick();

    // Flag write and BLT in the same cycle: old N=0 used
    flagWrEn = 1'b1; flagsIn = 2'b10;
    br(3'd3, 8'h20, 8'd2, 1'b0, 8'h00);
    flagWrEn = 1'b0;
    chk_out("blt_stale", 1'b0, 1'b0, 1'b0);
    br(3'd3, 8'h20, 8'd2, 1'b1, 8'h28);
    chk_out("blt_taken", 1'b1, 1'b1, 1'b1);
    tick(); tick();
    chk("pre_misal.alignErr", {31'd0, alignErr}, 32'd0);

    // Misaligned target 0x35 is cleared to 0x34 and alignErr sticks
    br(3'd0, 8'h31, 8'd1, 1'b1, 8'h34);
    chk("misal.alignErr", {31'd0, alignErr}, 32'd1);
    tick(); tick(); tick();
    chk("misal.alignErr_sticky", {31'd0, alignErr}, 32'd1);

    // Taken JMP, second JMP during flush dropped, reset at N+2
    br(3'd0, 8'h40, 8'd4, 1'b1, 8'h50);
    chk_out("b2b_n1", 1'b1, 1'b1, 1'b1);
    brType = 3'd0; brPc = 8'h80; brOffset = 8'd0; brValid = 1'b1;
    tick();
    brValid = 1'b0;
    chk_out("b2b_n2", 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("rst_n3", 1'b0, 1'b0, 1'b0);
    chk("rst_n3.newPc", {24'd0, newPc}, 32'd0);
    chk("rst_n3.alignErr", {31'd0, alignErr}, 32'd0);
    tick();
    chk_out("rst_n4", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst_n5", 1'b0, 1'b0, 1'b0);

    // Every queued redirect must have appeared
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Control-flow resolution block driving the fetch stage's PC write port (`pcWrEn`, `newPc`). It takes resolved branch/jump requests from execute, evaluates the condition against a registered flag set, and issues a one-cycle PC redirect. It then holds flush requests on the IF/ID and ID/EX pipeline registers long enough to squash wrong-path instructions. It sits between the execute stage and the fetch stage of the ASIP pipeline.

## Interface
- `PC_W`, 8: PC width; matches the 8-bit instruction address.
- `PC_STEP`, 4: byte distance between sequential instructions.
- `FLUSH_CYCLES`, 2: cycles of flush after a redirect; legal range 1..7.
- `clk`  in  1  clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; all state to reset values.
- `flagWrEn`  in  1  load `flagsIn` into the flag register.
- `flagsIn`  in  2  {N, Z} from the ALU.
- `brValid`  in  1  control-flow instruction present in execute this cycle.
- `brType`  in  3  0 JMP, 1 BEQ (Z), 2 BNE (!Z), 3 BLT (N), 4 BGE (!N); 5..7 reserved.
- `brPc`  in  PC_W  address of the branch instruction.
- `brOffset`  in  PC_W  signed offset in instructions.
- `pcWrEn`  out  1  redirect pulse to fetch.
- `newPc`  out  PC_W  redirect target.
- `flushIF`  out  1  squash the IF/ID register.
- `flushID`  out  1  squash the ID/EX register.
- `busy`  out  1  redirect or flush in progress.
- `alignErr`  out  1  sticky error: a target was misaligned.

## Operation
- Flag register: 2 bits, reset 0, loaded when `flagWrEn`=1.
- Taken condition: evaluated combinationally from the registered flags and `brType`. Types 5..7 are never taken.
- Target: `brPc + (brOffset * PC_STEP)`, computed modulo 2^PC_W, with wrap-around allowed (0xFC + 4 = 0x00).
- Alignment: if `target % PC_STEP != 0`, the low bits are cleared before driving `newPc` and `alignErr` sets. `alignErr` clears only on reset.
- FSM states:
  - IDLE → REDIRECT on `brValid` and taken.
  - REDIRECT → FLUSH (one cycle).
  - FLUSH → IDLE after the counter expires.
  - A not-taken branch stays in IDLE and produces no outputs.
- In REDIRECT:
  - `pcWrEn`=1 and `newPc`=target.
  - `flushIF`=`flushID`=1.
  - Flush counter loads FLUSH_CYCLES-1.
- In FLUSH:
  - `flushIF`=`flushID`=1.
  - Counter decrements; when it reaches 0, the state returns to IDLE.
- In REDIRECT and FLUSH, `brValid` is ignored because it belongs to the wrong path.
- `busy`=1 in REDIRECT and FLUSH.
- When `pcWrEn`=0, `newPc` holds its last value.

## Timing
- Reset values:
  - `pcWrEn`, `flushIF`, `flushID`, `busy`, `alignErr` = 0.
  - `newPc` = 0.
  - Flags = 0; state IDLE; counter 0.
- All outputs are registered.
- Taken branch sampled at edge of cycle N → `pcWrEn` high during N+1 → fetch PC equals target in N+2.
- Flush is high during cycles N+1 .. N+FLUSH_CYCLES.
- `brValid` is accepted again from cycle N+FLUSH_CYCLES+1.
- `flagWrEn` and `brValid` in the same cycle: the branch uses the pre-update flags.
- Reset mid-REDIRECT or mid-FLUSH: all outputs are 0 the next cycle, and the pending flush is abandoned.
- Back-to-back taken branches: the second one is dropped if it arrives while `busy`=1.

## Configuration
- `PC_REDIRECT_STATS_EN` defined:
  - Adds outputs `takenCnt[15:0]` and `notTakenCnt[15:0]`.
  - Counters increment on each evaluated branch in IDLE, saturate at 0xFFFF, and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `asip_pkg`:
  - `PC_W`, `PC_STEP`.
  - Branch-type enum `br_type_t` (JMP, BEQ, BNE, BLT, BGE).
  - FSM state enum `redir_state_t`.
- Sub-module `branch_cond`: combinational, {`brType`, N, Z} → taken.
- Flag register, target adder, FSM and flush counter live in the top module.

## Test plan
- Reset, then 3 idle cycles → all outputs 0, `busy`=0.
- Flags Z=1, BEQ with `brPc`=0x10, `brOffset`=3 at cycle N → `pcWrEn`=1 and `newPc`=0x1C at N+1; flush high N+1..N+2; `busy` low at N+3.
- Flags Z=1, BNE → no `pcWrEn`, no flush, state stays IDLE.
- JMP with `brPc`=0xFC, `brOffset`=1 → `newPc`=0x00. JMP with `brOffset`=-2 from 0x04 → `newPc`=0xFC.
- `flagWrEn` with N=1 in the same cycle as BLT → not taken. Repeat BLT next cycle → taken.
- Taken JMP, then another JMP during flush → only the first redirect occurs. `reset` at N+2 → all outputs 0 at N+3.
